// File: rtl/bram_be_pipe.sv
// Simple dual-port block RAM with per-byte write enables, a 1..3 cycle
// registered read pipeline with valid strobe, and a selectable
// same-address read-during-write result (old or merged new data).
module bram_be_pipe #(
   parameter int    LINES      = 1024,
   parameter int    DW         = 32,
   parameter int    BW         = 8,
   parameter int    RD_LATENCY = 2,
   parameter int    RDW_MODE   = 0,
   parameter string INIT_FILE  = ""
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_en_i,
   input  logic [$clog2(LINES)-1:0] wr_addr_i,
   input  logic [DW-1:0]            wr_d_i,
   input  logic [DW/BW-1:0]         wr_be_i,
   input  logic                     rd_en_i,
   input  logic [$clog2(LINES)-1:0] rd_addr_i,
   output logic [DW-1:0]            rd_d_o,
   output logic                     rd_valid_o
);

   localparam int AW = $clog2(LINES);
   localparam int NB = DW / BW;
   // Stage count clamped so an illegal latency still elaborates far
   // enough for the error below to be reported.
   localparam int NS = (RD_LATENCY >= 1 && RD_LATENCY <= 3) ? RD_LATENCY : 1;
   // LINES in AW+1 bits so range checks work when LINES is a power of two.
   localparam logic [AW:0] LINES_C = (AW + 1)'(LINES);

   if (DW % BW != 0) begin : g_err_dw
      $error("bram_be_pipe: DW must be a multiple of BW");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_err_lat
      $error("bram_be_pipe: RD_LATENCY must be 1..3");
   end
   if (LINES < 2) begin : g_err_lines
      $error("bram_be_pipe: LINES must be at least 2");
   end

   // Storage; never reset so it maps onto block RAM.
   logic [DW-1:0] mem_q [LINES];

   logic          wr_ok;
   logic          rd_in_range;
   logic          rdw_hit;
   logic [NB-1:0] lane_we;
   logic [DW-1:0] rd_word;
   logic [DW-1:0] s1_word;

   // Request qualification: reset blocks writes, out-of-range writes are dropped.
   always_comb begin
      wr_ok       = rst_ni && wr_en_i && ({1'b0, wr_addr_i} < LINES_C);
      rd_in_range = ({1'b0, rd_addr_i} < LINES_C);
      rdw_hit     = (RDW_MODE == 1) && wr_ok && (wr_addr_i == rd_addr_i);
   end

   assign rd_word = rd_in_range ? mem_q[rd_addr_i] : '0;

   // Per-lane write strobes and the new-data bypass in front of stage 1.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_we[gi] = wr_ok & wr_be_i[gi];
      assign s1_word[gi*BW +: BW] = (rdw_hit && wr_be_i[gi]) ? wr_d_i[gi*BW +: BW]
                                                             : rd_word[gi*BW +: BW];
   end

   // Byte-lane write into the array.
   always @(posedge clk_i) begin
      for (int k = 0; k < NB; k++) begin
         if (lane_we[k]) begin
            mem_q[wr_addr_i][k*BW +: BW] <= wr_d_i[k*BW +: BW];
         end
      end
   end

   logic [NS-1:0]         vld_q, vld_d;
   logic [NS-1:0][DW-1:0] dat_q, dat_d;

   // Read pipeline next state: data stages load only when their valid is set,
   // so the output holds the last returned word between pulses.
   always_comb begin
      vld_d    = vld_q;
      dat_d    = dat_q;
      vld_d[0] = rd_en_i;
      if (rd_en_i) begin
         dat_d[0] = s1_word;
      end
      for (int s = 1; s < NS; s++) begin
         vld_d[s] = vld_q[s-1];
         if (vld_q[s-1]) begin
            dat_d[s] = dat_q[s-1];
         end
      end
   end

   // Read pipeline registers; reset drops all in-flight reads.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign rd_valid_o = vld_q[NS-1];
   assign rd_d_o     = dat_q[NS-1];

endmodule

// File: tb/tb_bram_be_pipe.sv
// Bench for bram_be_pipe: three instances (latency 1/old, 2/new, 3/old data)
// share one stimulus stream; expected read words are queued when a request
// is driven and compared when each instance is due to return it.
module tb_bram_be_pipe;

   localparam int LINES = 1000;
   localparam int DW    = 32;
   localparam int BW    = 8;
   localparam int NB    = DW / BW;
   localparam int AW    = $clog2(LINES);
   localparam int ND    = 3;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   wr_en;
   logic [AW-1:0]          wr_addr;
   logic [DW-1:0]          wr_d;
   logic [NB-1:0]          wr_be;
   logic                   rd_en;
   logic [AW-1:0]          rd_addr;
   logic [ND-1:0][DW-1:0]  rd_d;
   logic [ND-1:0]          rd_valid;

   always #5 clk = ~clk;

   bram_be_pipe #(.LINES(LINES), .DW(DW), .BW(BW), .RD_LATENCY(1), .RDW_MODE(0), .INIT_FILE("")) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_d_i(wr_d),
      .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_d_o(rd_d[0]), .rd_valid_o(rd_valid[0]));
   bram_be_pipe #(.LINES(LINES), .DW(DW), .BW(BW), .RD_LATENCY(2), .RDW_MODE(1), .INIT_FILE("")) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_d_i(wr_d),
      .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_d_o(rd_d[1]), .rd_valid_o(rd_valid[1]));
   bram_be_pipe #(.LINES(LINES), .DW(DW), .BW(BW), .RD_LATENCY(3), .RDW_MODE(0), .INIT_FILE("")) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_d_i(wr_d),
      .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_d_o(rd_d[2]), .rd_valid_o(rd_valid[2]));

   function automatic int lat_of(input int j);
      return j + 1;
   endfunction

   function automatic bit rdw_of(input int j);
      return (j == 1);
   endfunction

   typedef struct {
      int            dut;
      int            due;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [NB-1:0] be;
      logic          re;
      logic [AW-1:0] ra;
      logic [DW-1:0] e_old;
      logic [DW-1:0] e_new;
   } vec_t;

   exp_t          sb[$];
   vec_t          tbl[$];
   logic [DW-1:0] last_d [ND];
   int            cyc;
   int            n_chk;
   int            n_fail;

   function automatic vec_t v(input bit we, input int wa, input logic [DW-1:0] wd,
                              input logic [NB-1:0] be, input bit re, input int ra,
                              input logic [DW-1:0] e_old, input logic [DW-1:0] e_new);
      vec_t r;
      r.we = we; r.wa = AW'(wa); r.wd = wd; r.be = be;
      r.re = re; r.ra = AW'(ra); r.e_old = e_old; r.e_new = e_new;
      return r;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input vec_t r);
      wr_en = r.we; wr_addr = r.wa; wr_d = r.wd; wr_be = r.be;
      rd_en = r.re; rd_addr = r.ra;
   endtask

   // One clock edge: queue expectations for the request being sampled,
   // then check every instance 1 time unit after the edge.
   task automatic step(input logic [DW-1:0] e_old, input logic [DW-1:0] e_new);
      exp_t e;
      int   found;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         sb.delete();
      end else if (rd_en) begin
         for (int j = 0; j < ND; j++) begin
            e.dut  = j;
            e.due  = cyc + lat_of(j) - 1;
            e.data = rdw_of(j) ? e_new : e_old;
            sb.push_back(e);
         end
      end
      #1;
      for (int j = 0; j < ND; j++) begin
         found = -1;
         for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].dut == j) begin
               found = i;
               break;
            end
         end
         if (!rst_n) begin
            last_d[j] = '0;
            chk($sformatf("dut%0d rst_valid", j), DW'(rd_valid[j]), '0);
            chk($sformatf("dut%0d rst_data", j), rd_d[j], '0);
         end else if (found >= 0 && sb[found].due == cyc) begin
            chk($sformatf("dut%0d valid", j), DW'(rd_valid[j]), DW'(1));
            chk($sformatf("dut%0d data", j), rd_d[j], sb[found].data);
            $display("dut%0d cyc %0d read return %h (expected %h)", j, cyc, rd_d[j], sb[found].data);
            last_d[j] = sb[found].data;
            sb.delete(found);
         end else begin
            chk($sformatf("dut%0d idle_valid", j), DW'(rd_valid[j]), '0);
            chk($sformatf("dut%0d hold_data", j), rd_d[j], last_d[j]);
         end
      end
   endtask

   task automatic idle(input int n);
      drive(v(0, 0, '0, '0, 0, 0, '0, '0));
      repeat (n) step('0, '0);
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0;
      for (int j = 0; j < ND; j++) last_d[j] = '0;

      // Reset held 3 cycles with a read requested; then idle after release.
      rst_n = 1'b0;
      drive(v(0, 0, '0, '0, 1, 0, '0, '0));
      repeat (3) step('0, '0);
      rst_n = 1'b1;
      idle(3);

      // Fill addresses 0..7 with their own index.
      for (int i = 0; i < 8; i++) tbl.push_back(v(1, i, DW'(i), 4'hF, 0, 0, '0, '0));
      // Streaming reads 0..7 with unrelated concurrent writes.
      for (int i = 0; i < 8; i++) tbl.push_back(v(1, 100 + i, DW'(32'hA0 + i), 4'hF, 1, i, DW'(i), DW'(i)));
      tbl.push_back(v(0, 0, '0, '0, 0, 0, '0, '0));
      tbl.push_back(v(0, 0, '0, '0, 1, 3, 32'h3, 32'h3));
      tbl.push_back(v(0, 0, '0, '0, 0, 0, '0, '0));
      tbl.push_back(v(0, 0, '0, '0, 1, 104, 32'hA4, 32'hA4));
      // Byte enables.
      tbl.push_back(v(1, 5, 32'hAABBCCDD, 4'b1111, 0, 0, '0, '0));
      tbl.push_back(v(1, 5, 32'h11223344, 4'b0101, 0, 0, '0, '0));
      tbl.push_back(v(0, 0, '0, '0, 1, 5, 32'hAA22CC44, 32'hAA22CC44));
      // Read during write, same address.
      tbl.push_back(v(1, 9, 32'h12345678, 4'b1111, 0, 0, '0, '0));
      tbl.push_back(v(1, 9, 32'hFFFFFFFF, 4'b0011, 1, 9, 32'h12345678, 32'h1234FFFF));
      tbl.push_back(v(0, 0, '0, '0, 1, 9, 32'h1234FFFF, 32'h1234FFFF));
      // Write to the address of an in-flight read.
      tbl.push_back(v(1, 12, 32'h0BADF00D, 4'b1111, 0, 0, '0, '0));
      tbl.push_back(v(0, 0, '0, '0, 1, 12, 32'h0BADF00D, 32'h0BADF00D));
      tbl.push_back(v(1, 12, 32'hDEADBEEF, 4'b1111, 1, 12, 32'h0BADF00D, 32'hDEADBEEF));
      tbl.push_back(v(0, 0, '0, '0, 1, 12, 32'hDEADBEEF, 32'hDEADBEEF));
      // All-zero byte enables and deasserted write enable are no-ops.
      tbl.push_back(v(1, 5, 32'hFFFFFFFF, 4'b0000, 0, 0, '0, '0));
      tbl.push_back(v(0, 5, 32'h00000000, 4'b1111, 1, 5, 32'hAA22CC44, 32'hAA22CC44));
      tbl.push_back(v(0, 0, '0, '0, 1, 5, 32'hAA22CC44, 32'hAA22CC44));
      // Out-of-range addresses.
      tbl.push_back(v(1, 10, 32'h10101010, 4'hF, 0, 0, '0, '0));
      tbl.push_back(v(1, 999, 32'h99999999, 4'hF, 0, 0, '0, '0));
      tbl.push_back(v(1, 0, 32'hC0C0C0C0, 4'hF, 0, 0, '0, '0));
      tbl.push_back(v(1, 1010, 32'hDEADDEAD, 4'hF, 0, 0, '0, '0));
      tbl.push_back(v(1, 1010, 32'h55555555, 4'hF, 1, 1010, '0, '0));
      tbl.push_back(v(0, 0, '0, '0, 1, 1010, '0, '0));
      tbl.push_back(v(0, 0, '0, '0, 1, 0, 32'hC0C0C0C0, 32'hC0C0C0C0));
      tbl.push_back(v(0, 0, '0, '0, 1, 999, 32'h99999999, 32'h99999999));
      tbl.push_back(v(0, 0, '0, '0, 1, 10, 32'h10101010, 32'h10101010));
      tbl.push_back(v(0, 0, '0, '0, 1, 1023, '0, '0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         step(tbl[i].e_old, tbl[i].e_new);
      end
      idle(4);

      // Reset mid-flight: two reads, then a one-cycle reset that also
      // carries a write and a read which must both be ignored.
      drive(v(0, 0, '0, '0, 1, 9, 32'h1234FFFF, 32'h1234FFFF));
      step(32'h1234FFFF, 32'h1234FFFF);
      drive(v(0, 0, '0, '0, 1, 12, 32'hDEADBEEF, 32'hDEADBEEF));
      step(32'hDEADBEEF, 32'hDEADBEEF);
      rst_n = 1'b0;
      drive(v(1, 0, 32'hBAD0BAD0, 4'hF, 1, 9, '0, '0));
      step('0, '0);
      rst_n = 1'b1;
      idle(3);

      // Contents survive reset.
      drive(v(0, 0, '0, '0, 1, 0, '0, '0));
      step(32'hC0C0C0C0, 32'hC0C0C0C0);
      drive(v(0, 0, '0, '0, 1, 9, '0, '0));
      step(32'h1234FFFF, 32'h1234FFFF);
      drive(v(0, 0, '0, '0, 1, 12, '0, '0));
      step(32'hDEADBEEF, 32'hDEADBEEF);
      drive(v(0, 0, '0, '0, 1, 999, '0, '0));
      step(32'h99999999, 32'h99999999);

      // Drain outstanding returns within a bounded number of cycles.
      for (int k = 0; k < 5 && sb.size() != 0; k++) idle(1);
      chk("drain_outstanding", DW'(sb.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
